uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer between the UART receiver's AXI-stream output and the memory-mapped UART bus wrapper.
- Absorbs bursts so the CPU need not service every byte within one character time.
- Provides an occupancy count and a sticky overflow flag.
- Generates a level interrupt on a fill threshold or on an idle character timeout, in the style of a 16550 UART.

Parameters:
- DATA_WIDTH, 8, width of one received character.
- DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 entries (16).
- IRQ_THRESH, 8, irq asserts when count >= IRQ_THRESH; legal range 1..2**DEPTH_LOG2.
- TIMEOUT_CYCLES, 32'd4096, idle clocks with FIFO non-empty before the timeout flag sets; minimum 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_tdata  in  DATA_WIDTH  character from the UART receiver.
- s_tvalid  in  1  character valid; a 1-cycle pulse per character.
- s_tready  out  1  always 1; the FIFO never back-pressures the receiver.
- m_tdata  out  DATA_WIDTH  head-of-FIFO character, first-word-fall-through.
- m_tvalid  out  1  FIFO non-empty.
- m_tready  in  1  consumer pops the head when m_tvalid && m_tready.
- clear  in  1  synchronous flush.
- count  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
- overflow  out  1  sticky; a character was dropped because the FIFO was full.
- irq  out  1  level interrupt.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr, rd_ptr and count = 0; overflow = 0; timeout flag = 0; idle counter = 0.
  - Outputs during reset: m_tvalid = 0, irq = 0, count = 0, s_tready = 1.
  - m_tdata is don't-care while m_tvalid = 0.
  - Storage RAM is not reset.
  - Deassertion of rst_n is used as-is (no internal synchronizer); the integrator supplies a synchronized deassert.
- Pointers: DEPTH_LOG2 bits each, natural binary wrap from 2**DEPTH_LOG2-1 to 0. full = (count == 2**DEPTH_LOG2); empty = (count == 0).
- Push = s_tvalid && (!full || pop). Data is written at wr_ptr and wr_ptr increments.
- Pop = m_tvalid && m_tready. rd_ptr increments.
- Count update per cycle:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Latency: a character pushed in cycle N appears on m_tdata/m_tvalid in cycle N+1. A pop in cycle N exposes the next entry in cycle N+1.
- Full and push in the same cycle as a pop: the push is accepted (count stays at maximum, no overflow).
- Full and push with no pop: the character is dropped, overflow sets in the next cycle, and storage and pointers are unchanged.
- Overflow clears only on clear or reset. It is not cleared by pops.
- Empty FIFO: m_tvalid = 0 and m_tready is ignored; no pointer movement, no underflow.
- Idle timer (32-bit counter):
  - Cleared to 0 on any push, any pop, or when empty.
  - Otherwise increments by 1 per cycle, saturating at TIMEOUT_CYCLES-1.
  - When the counter equals TIMEOUT_CYCLES-1 with the FIFO non-empty, the timeout flag sets on the next edge.
  - The timeout flag clears on any pop, on clear, or on reset. A push alone does not clear it.
- irq = (count >= IRQ_THRESH) || timeout flag. It is registered from the post-update state, so irq changes one cycle after the count or flag changes.
- clear: on the next edge, pointers, count, overflow, timeout flag and idle counter go to 0.
  - clear has priority over a simultaneous push or pop; a character arriving in the clear cycle is dropped and does not set overflow.
- Asynchronous reset mid-operation aborts everything immediately. A character presented during reset is lost.

Test Plan:
- Push 0x41, 0x42, 0x43 on separate cycles with m_tready = 0 -> count = 3 and m_tdata = 0x41 one cycle after the first push. Then hold m_tready = 1 -> pops 0x41, 0x42, 0x43 in order, m_tvalid = 0 after the third pop, count = 0.
- Push 17 characters 0x00..0x10 with no pops (DEPTH_LOG2 = 4) -> count = 16; 0x10 is dropped; overflow = 1 from the cycle after the 17th push. Draining returns 0x00..0x0F. overflow stays 1 until a clear pulse drives it to 0.
- Fill to 16, then present push 0x55 and pop in the same cycle -> overflow stays 0, count stays 16, and 0x55 is the last character drained.
- IRQ_THRESH = 8: push 7 characters -> irq = 0; push an 8th -> irq = 1 one cycle later. Pop one -> irq = 0 one cycle later.
- TIMEOUT_CYCLES = 16, push a single character with no pops -> irq = 1 exactly 17 cycles after the push cycle. One pop -> irq = 0 next cycle and count = 0.
- Pulse rst_n low for 1 cycle with count = 5 and overflow = 1 -> count, m_tvalid, overflow and irq are 0 immediately (asynchronously). The next push after release yields count = 1.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - character stream handshake between receiver, buffer and bus wrapper
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with occupancy, sticky overflow and 16550-style irq
module uart_rx_fifo #(
  parameter int          DATA_WIDTH     = 8,
  parameter int          DEPTH_LOG2     = 4,
  parameter int          IRQ_THRESH     = 8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd4096
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_rx_fifo_if.slave       s,
  uart_rx_fifo_if.master      m,
  input  logic                clear,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  output logic                irq
);
  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT   = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] THRESH_CNT = (DEPTH_LOG2 + 1)'(IRQ_THRESH);
  localparam logic [31:0]         IDLE_MAX   = TIMEOUT_CYCLES - 32'd1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [31:0]           idle_cnt;
  logic                  tmo_flag;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  tmo_nxt;
  logic                  irq_nxt;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop      = !empty && m.tready;
  // A full FIFO still accepts a character when the head leaves in the same cycle.
  assign push     = s.tvalid && (!full || pop);
  assign s.tready = 1'b1;
  assign m.tvalid = !empty;
  assign m.tdata  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    tmo_nxt   = tmo_flag;
    if (clear) begin
      count_nxt = '0;
      tmo_nxt   = 1'b0;
    end else begin
      if (push && !pop)
        count_nxt = count + 1'b1;
      else if (pop && !push)
        count_nxt = count - 1'b1;
      if (pop)
        tmo_nxt = 1'b0;
      else if (!empty && idle_cnt == IDLE_MAX)
        tmo_nxt = 1'b1;
    end
    // irq follows the post-update state so it lands one cycle after the cause.
    irq_nxt = (count_nxt >= THRESH_CNT) || tmo_nxt;
  end

  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[wr_ptr] <= s.tdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tmo_flag <= 1'b0;
      idle_cnt <= '0;
      irq      <= 1'b0;
    end else begin
      count    <= count_nxt;
      tmo_flag <= tmo_nxt;
      irq      <= irq_nxt;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
        idle_cnt <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (s.tvalid && full && !pop)
          overflow <= 1'b1;
        if (push || pop || empty)
          idle_cnt <= '0;
        else if (idle_cnt != IDLE_MAX)
          idle_cnt <= idle_cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [4:0] count;
  logic       overflow;
  logic       irq;

  uart_rx_fifo_if #(.DATA_WIDTH(8)) s_if ();
  uart_rx_fifo_if #(.DATA_WIDTH(8)) m_if ();

  uart_rx_fifo #(
    .DATA_WIDTH(8),
    .DEPTH_LOG2(4),
    .IRQ_THRESH(8),
    .TIMEOUT_CYCLES(32'd16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s(s_if),
    .m(m_if),
    .clear(clear),
    .count(count),
    .overflow(overflow),
    .irq(irq)
  );

  int        n_cmp;
  int        n_fail;
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_char(input logic [7:0] d, input bit expect_kept);
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    if (expect_kept)
      exp_q.push_back(d);
    cycle();
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain(input int n);
    m_if.tready = 1'b1;
    repeat (n) cycle();
    m_if.tready = 1'b0;
  endtask

  // Pops happen on the next rising edge; inputs are stable around the falling edge.
  always @(negedge clk) begin
    if (rst_n && m_if.tvalid && m_if.tready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_data: got 0x%0h expected no character", m_if.tdata);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (m_if.tdata !== e) begin
          n_fail++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", m_if.tdata, e);
        end
      end
    end
  end

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    clear       = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 8'h00;
    m_if.tready = 1'b0;
    #2;
    check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_s_tready", 32'(s_if.tready), 32'd1);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // three characters, first-word-fall-through, in-order drain
    push_char(8'h41, 1'b1);
    check("fwft_valid", 32'(m_if.tvalid), 32'd1);
    check("fwft_data", 32'(m_if.tdata), 32'h41);
    push_char(8'h42, 1'b1);
    push_char(8'h43, 1'b1);
    check("count3", 32'(count), 32'd3);
    drain(3);
    check("empty_after3_valid", 32'(m_if.tvalid), 32'd0);
    check("empty_after3_count", 32'(count), 32'd0);

    // overfill: seventeenth character dropped, overflow sticky until clear
    for (int i = 0; i < 16; i++)
      push_char(8'(i), 1'b1);
    check("full_count", 32'(count), 32'd16);
    check("full_no_ovf", 32'(overflow), 32'd0);
    push_char(8'h10, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    drain(16);
    check("ovf_drained_count", 32'(count), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++)
      push_char(8'h80 + 8'(i), 1'b1);
    m_if.tready = 1'b1;
    push_char(8'h55, 1'b1);
    m_if.tready = 1'b0;
    check("pushpop_full_count", 32'(count), 32'd16);
    check("pushpop_full_ovf", 32'(overflow), 32'd0);
    drain(16);
    check("pushpop_drained", 32'(exp_q.size()), 32'd0);

    // threshold interrupt
    for (int i = 0; i < 7; i++)
      push_char(8'hA0 + 8'(i), 1'b1);
    check("irq_below_thresh", 32'(irq), 32'd0);
    push_char(8'hA7, 1'b1);
    check("irq_at_thresh", 32'(irq), 32'd1);
    drain(1);
    check("irq_after_pop", 32'(irq), 32'd0);
    check("irq_after_pop_count", 32'(count), 32'd7);
    drain(7);

    // idle timeout: irq exactly 17 cycles after the push cycle
    push_char(8'h5A, 1'b1);
    repeat (15) cycle();
    check("tmo_not_yet", 32'(irq), 32'd0);
    cycle();
    check("tmo_irq", 32'(irq), 32'd1);
    drain(1);
    check("tmo_cleared_irq", 32'(irq), 32'd0);
    check("tmo_cleared_count", 32'(count), 32'd0);

    // asynchronous reset mid-operation
    for (int i = 0; i < 16; i++)
      push_char(8'hC0 + 8'(i), 1'b1);
    push_char(8'hD0, 1'b0);
    drain(11);
    check("pre_rst_count", 32'(count), 32'd5);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_valid", 32'(m_if.tvalid), 32'd0);
    check("async_rst_ovf", 32'(overflow), 32'd0);
    check("async_rst_irq", 32'(irq), 32'd0);
    exp_q.delete();
    cycle();
    rst_n = 1'b1;
    push_char(8'h77, 1'b1);
    check("post_rst_count", 32'(count), 32'd1);
    drain(1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
